// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared OKI ADPCM step, index-delta and gain tables
package jt6295_pkg;
  localparam int PRED_MAX = 2047;
  localparam int PRED_MIN = -2048;
  localparam int STEP_TAB [49] = '{
    16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
    107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
    494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  localparam int IDX_DELTA [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  localparam int GAIN_TAB [16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};
  function automatic logic [10:0] step_of(input logic [5:0] i);
    return 11'(STEP_TAB[i]);
  endfunction
endpackage

// File: rtl/jt6295_adpcm_step.sv
// jt6295_adpcm_step: combinational ADPCM difference and clamped next step index
module jt6295_adpcm_step import jt6295_pkg::*; (
  input  logic [10:0] s,
  input  logic [3:0]  nibble,
  input  logic [5:0]  i,
  output logic [11:0] diff,
  output logic [5:0]  idx
);
  logic signed [7:0] ni;
  always_comb begin
    diff = 12'(s >> 3) + (nibble[0] ? 12'(s >> 2) : 12'd0)
         + (nibble[1] ? 12'(s >> 1) : 12'd0) + (nibble[2] ? 12'(s) : 12'd0);
    ni = $signed({2'b0, i}) + $signed(8'(IDX_DELTA[nibble[2:0]]));
    idx = ni[7] ? 6'd0 : ni > 8'sd48 ? 6'd48 : ni[5:0];
  end
endmodule

// File: rtl/jt6295_adpcm_mc.sv
// jt6295_adpcm_mc: time-multiplexed OKI ADPCM decoder and mixer; JT6295_IDLE_DECAY_EN enables key-off decay
module jt6295_adpcm_mc import jt6295_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int MIXW = 14
)(
  input  logic clk,
  input  logic rst,
  input  logic cen,
  output logic [$clog2(CHANNELS)-1:0] slot,
  input  logic en,
  input  logic start,
  input  logic [3:0] att,
  input  logic [3:0] data,
  output logic signed [11:0] snd,
  output logic [$clog2(CHANNELS)-1:0] snd_ch,
  output logic snd_valid,
  output logic signed [MIXW-1:0] mix,
  output logic mix_valid
);
  localparam int CW = $clog2(CHANNELS);
  localparam int AW = 12 + CW + 1;
  localparam int MMAX = 2**(MIXW-1) - 1;
  localparam int MMIN = -(2**(MIXW-1));
  localparam logic [CW-1:0] LAST = CW'(CHANNELS-1);
  logic signed [11:0] pred [CHANNELS];
  logic [5:0] index [CHANNELS];
  logic v1, v2, v3, v4, en1, en2, sg2, sv, mv, fwd;
  logic [CW-1:0] c1, c2, c3, c4;
  logic signed [11:0] p1, p2, p3, p4, p_rd, p_next, p_idle, snd_next;
  logic [5:0] i1, i2, i3, i4, i_rd, i_new, g4;
  logic [10:0] s1;
  logic [3:0] d1, a1, a2, a3;
  logic [11:0] diff, diff2;
  logic signed [13:0] sum;
  logic signed [18:0] prod;
  logic signed [AW-1:0] acc, acc_sum;
  logic signed [MIXW-1:0] mix_sat;

  jt6295_adpcm_step u_step (.s(s1), .nibble(d1), .i(i1), .diff(diff), .idx(i_new));

  // the channel being written this tick is read back write-first
  always_comb begin
    fwd = v4 && c4 == slot;
    p_rd = fwd ? p4 : pred[slot];
    i_rd = fwd ? i4 : index[slot];
    sum = sg2 ? 14'(p2) - 14'(diff2) : 14'(p2) + 14'(diff2);
    p_next = int'(sum) > PRED_MAX ? 12'(PRED_MAX) : int'(sum) < PRED_MIN ? 12'(PRED_MIN) : sum[11:0];
`ifdef JT6295_IDLE_DECAY_EN
    p_idle = (p2 > -12'sd16 && p2 < 12'sd16) ? 12'sd0 : p2 - (p2 >>> 4);
`else
    p_idle = 12'sd0;
`endif
    prod = 19'(p4) * 19'(g4);
    snd_next = 12'(prod >>> 5);
    acc_sum = acc + AW'(snd_next);
    mix_sat = int'(acc_sum) > MMAX ? MIXW'(MMAX) : int'(acc_sum) < MMIN ? MIXW'(MMIN) : MIXW'(acc_sum);
  end

  always_ff @(posedge clk)
    if (rst) begin
      slot <= '0;
      {v1, v2, v3, v4, sv, mv} <= '0;
      snd <= '0;
      snd_ch <= '0;
      mix <= '0;
      acc <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        pred[k] <= '0;
        index[k] <= '0;
      end
    end else if (cen) begin
      slot <= slot == LAST ? '0 : slot + 1'b1;
      v1 <= 1'b1;
      c1 <= slot;
      en1 <= en;
      p1 <= start ? '0 : p_rd;
      i1 <= start ? '0 : i_rd;
      s1 <= step_of(start ? 6'd0 : i_rd);
      d1 <= data;
      a1 <= att;
      v2 <= v1;
      c2 <= c1;
      en2 <= en1;
      p2 <= p1;
      i2 <= i_new;
      diff2 <= diff;
      sg2 <= d1[3];
      a2 <= a1;
      v3 <= v2;
      c3 <= c2;
      p3 <= en2 ? p_next : p_idle;
      i3 <= en2 ? i2 : '0;
      a3 <= a2;
      v4 <= v3;
      c4 <= c3;
      p4 <= p3;
      i4 <= i3;
      g4 <= 6'(GAIN_TAB[a3]);
      sv <= v4;
      mv <= v4 && c4 == LAST;
      if (v4) begin
        pred[c4] <= p4;
        index[c4] <= i4;
        snd <= snd_next;
        snd_ch <= c4;
        acc <= c4 == LAST ? '0 : acc_sum;
        if (c4 == LAST) mix <= mix_sat;
      end
    end

  assign snd_valid = sv & cen;
  assign mix_valid = mv & cen;
endmodule

// File: tb/tb_jt6295_adpcm_mc.sv
// tb_jt6295_adpcm_mc: randomized self-checking bench against a sequential ADPCM reference model
module tb_jt6295_adpcm_mc;
  localparam int CH = 4;
  logic clk = 0, rst = 1, cen = 0, en = 0, start = 0;
  logic [3:0] att = 0, data = 0;
  logic [1:0] slot, snd_ch, slot12, snd_ch12;
  logic signed [11:0] snd, snd12, mix12;
  logic signed [13:0] mix;
  logic snd_valid, mix_valid, snd_valid12, mix_valid12;

  always #5 clk = ~clk;

  jt6295_adpcm_mc #(.CHANNELS(CH), .MIXW(14)) dut (
    .clk(clk), .rst(rst), .cen(cen), .slot(slot), .en(en), .start(start), .att(att), .data(data),
    .snd(snd), .snd_ch(snd_ch), .snd_valid(snd_valid), .mix(mix), .mix_valid(mix_valid));
  jt6295_adpcm_mc #(.CHANNELS(CH), .MIXW(12)) dut12 (
    .clk(clk), .rst(rst), .cen(cen), .slot(slot12), .en(en), .start(start), .att(att), .data(data),
    .snd(snd12), .snd_ch(snd_ch12), .snd_valid(snd_valid12), .mix(mix12), .mix_valid(mix_valid12));

  int checks = 0, failures = 0;
  int step_t [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
    107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
    494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  int gain_t [16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};
  int mp [CH], mi [CH];
  int n, fsum;
  typedef struct {int due; int ch; int snd;} exp_t;
  exp_t q[$];
  logic o_sv, o_mv, o_sv12, o_mv12, e_sv, e_mv;
  int o_snd, o_ch, o_mix, o_slot, o_snd12, o_mix12;
  int e_snd, e_ch, e_mix, e_mix12, e_slot;

  function automatic int sat(int v, int w);
    int hi = (1 << (w - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  function automatic int decode(int ch, bit e, bit st, int a, int d);
    int s, df;
    if (st) begin mp[ch] = 0; mi[ch] = 0; end
    if (!e) begin
`ifdef JT6295_IDLE_DECAY_EN
      mp[ch] = (mp[ch] > -16 && mp[ch] < 16) ? 0 : mp[ch] - (mp[ch] >>> 4);
`else
      mp[ch] = 0;
`endif
      mi[ch] = 0;
    end else begin
      s = step_t[mi[ch]];
      df = s / 8 + ((d & 1) != 0 ? s / 4 : 0) + ((d & 2) != 0 ? s / 2 : 0) + ((d & 4) != 0 ? s : 0);
      mp[ch] = sat(d >= 8 ? mp[ch] - df : mp[ch] + df, 12);
      mi[ch] = mi[ch] + ((d & 4) != 0 ? 2 * (d & 3) + 2 : -1);
      mi[ch] = mi[ch] < 0 ? 0 : mi[ch] > 48 ? 48 : mi[ch];
    end
    return (mp[ch] * gain_t[a]) >>> 5;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cen = 1; en = 0; start = 0;
    repeat (2) @(negedge clk);
    rst = 0; cen = 0;
    q.delete();
    n = 0; fsum = 0;
    for (int k = 0; k < CH; k++) begin mp[k] = 0; mi[k] = 0; end
  endtask

  task automatic tick(input bit e, input bit st, input int a, input int d);
    @(negedge clk);
    cen = 1; en = e; start = st; att = 4'(a); data = 4'(d);
    #1;
    o_sv = snd_valid; o_snd = int'(snd); o_ch = int'(snd_ch); o_mv = mix_valid; o_mix = int'(mix);
    o_slot = int'(slot); o_sv12 = snd_valid12; o_snd12 = int'(snd12); o_mv12 = mix_valid12; o_mix12 = int'(mix12);
    e_slot = n % CH; e_sv = 0; e_mv = 0;
    if (q.size() > 0 && q[0].due == n) begin
      e_sv = 1; e_snd = q[0].snd; e_ch = q[0].ch;
      void'(q.pop_front());
      fsum += e_snd;
      if (e_ch == CH - 1) begin
        e_mv = 1; e_mix = sat(fsum, 14); e_mix12 = sat(fsum, 12); fsum = 0;
      end
    end
    q.push_back('{n + 5, n % CH, decode(n % CH, e, st, a, d)});
    n++;
  endtask

  task automatic test_reset();
    do_reset();
    cen = 1;
    #1;
    checks++;
    if (slot !== 2'd0 || snd !== 12'sd0 || snd_ch !== 2'd0) begin
      failures++; $display("FAIL reset_regs slot=%0d snd=%0d ch=%0d need 0 0 0", slot, snd, snd_ch);
    end
    checks++;
    if (mix !== 14'sd0 || mix12 !== 12'sd0) begin
      failures++; $display("FAIL reset_mix mix=%0d mix12=%0d need 0 0", mix, mix12);
    end
    checks++;
    if (snd_valid !== 1'b0 || mix_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid snd_valid=%0b mix_valid=%0b need 0 0", snd_valid, mix_valid);
    end
    cen = 0;
  endtask

  task automatic test_decode();
    int dl [19];
    int ch0 [$];
    do_reset();
    for (int f = 0; f < 19; f++) dl[f] = f == 0 ? 7 : f == 1 ? 8 : f < 16 ? 7 : 15;
    for (int f = 0; f < 22; f++)
      for (int c = 0; c < CH; c++) begin
        tick(c == 0 && f < 19, 0, 0, (c == 0 && f < 19) ? dl[f] : int'($urandom_range(0, 15)));
        if (o_sv && o_ch == 0) ch0.push_back(o_snd);
        checks++;
        if (o_slot !== e_slot || o_sv !== e_sv || o_sv12 !== e_sv || (e_sv && (o_snd !== e_snd || o_ch !== e_ch || o_snd12 !== e_snd))) begin
          failures++;
          $display("FAIL decode_snd tick=%0d slot=%0d v=%0b snd=%0d ch=%0d need slot=%0d v=%0b snd=%0d ch=%0d",
                   n - 1, o_slot, o_sv, o_snd, o_ch, e_slot, e_sv, e_snd, e_ch);
        end
        checks++;
        if (o_mv !== e_mv || o_mv12 !== e_mv || (e_mv && (o_mix !== e_mix || o_mix12 !== e_mix12))) begin
          failures++;
          $display("FAIL decode_mix tick=%0d v=%0b mix=%0d mix12=%0d need v=%0b mix=%0d mix12=%0d",
                   n - 1, o_mv, o_mix, o_mix12, e_mv, e_mix, e_mix12);
        end
      end
    checks++;
    if (ch0.size() < 21) begin
      failures++; $display("FAIL ch0_count got=%0d need>=21", ch0.size());
    end else begin
      checks++;
      if (ch0[0] != 30) begin failures++; $display("FAIL first_0111 got=%0d need=30", ch0[0]); end
      checks++;
      if (ch0[1] != 26) begin failures++; $display("FAIL then_1000 got=%0d need=26", ch0[1]); end
      checks++;
      if (ch0[15] != 2047) begin failures++; $display("FAIL sat_high got=%0d need=2047", ch0[15]); end
      checks++;
      if (ch0[16] != 2047 - 2910) begin failures++; $display("FAIL no_wrap got=%0d need=%0d", ch0[16], 2047 - 2910); end
      checks++;
      if (ch0[17] != -2048) begin failures++; $display("FAIL sat_low got=%0d need=-2048", ch0[17]); end
`ifndef JT6295_IDLE_DECAY_EN
      checks++;
      if (ch0[19] != 0) begin failures++; $display("FAIL disabled_zero got=%0d need=0", ch0[19]); end
`endif
    end
    @(negedge clk);
    cen = 0;
  endtask

  task automatic test_mix();
    int mvc = 0, lm = 0, lm12 = 0;
    do_reset();
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < CH; c++) begin
        tick(1, 0, 0, f < 8 ? 7 : 15);
        if (o_mv) begin mvc++; lm = o_mix; lm12 = o_mix12; end
        checks++;
        if (o_slot !== e_slot || o_sv !== e_sv || o_sv12 !== e_sv || (e_sv && (o_snd !== e_snd || o_ch !== e_ch || o_snd12 !== e_snd))) begin
          failures++;
          $display("FAIL mix_snd tick=%0d slot=%0d v=%0b snd=%0d ch=%0d need slot=%0d v=%0b snd=%0d ch=%0d",
                   n - 1, o_slot, o_sv, o_snd, o_ch, e_slot, e_sv, e_snd, e_ch);
        end
        checks++;
        if (o_mv !== e_mv || o_mv12 !== e_mv || (e_mv && (o_mix !== e_mix || o_mix12 !== e_mix12))) begin
          failures++;
          $display("FAIL mix_frame tick=%0d v=%0b mix=%0d mix12=%0d need v=%0b mix=%0d mix12=%0d",
                   n - 1, o_mv, o_mix, o_mix12, e_mv, e_mix, e_mix12);
        end
      end
      if (f == 7) begin
        checks++;
        if (lm != 8188 || lm12 != 2047) begin
          failures++; $display("FAIL mix_pos mix=%0d mix12=%0d need 8188 2047", lm, lm12);
        end
      end
    end
    checks++;
    if (lm != -8192 || lm12 != -2048) begin
      failures++; $display("FAIL mix_neg mix=%0d mix12=%0d need -8192 -2048", lm, lm12);
    end
    checks++;
    if (mvc != 14) begin failures++; $display("FAIL mix_count got=%0d need=14", mvc); end
    @(negedge clk);
    cen = 0;
  endtask

  task automatic test_random();
    int got = -99999;
    do_reset();
    for (int k = 0; k < 309; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        cen = 0;
        #1;
        checks++;
        if (snd_valid !== 1'b0 || mix_valid !== 1'b0 || int'(slot) !== n % CH) begin
          failures++;
          $display("FAIL cen_hold snd_valid=%0b mix_valid=%0b slot=%0d need 0 0 %0d", snd_valid, mix_valid, slot, n % CH);
        end
      end
      if (k == 302) tick(1, 1, 0, 7);
      else tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
      if (n - 1 == 307 && o_sv && o_ch == 2) got = o_snd;
      checks++;
      if (o_slot !== e_slot || o_sv !== e_sv || o_sv12 !== e_sv || (e_sv && (o_snd !== e_snd || o_ch !== e_ch || o_snd12 !== e_snd))) begin
        failures++;
        $display("FAIL rand_snd tick=%0d slot=%0d v=%0b snd=%0d ch=%0d need slot=%0d v=%0b snd=%0d ch=%0d",
                 n - 1, o_slot, o_sv, o_snd, o_ch, e_slot, e_sv, e_snd, e_ch);
      end
      checks++;
      if (o_mv !== e_mv || o_mv12 !== e_mv || (e_mv && (o_mix !== e_mix || o_mix12 !== e_mix12))) begin
        failures++;
        $display("FAIL rand_mix tick=%0d v=%0b mix=%0d mix12=%0d need v=%0b mix=%0d mix12=%0d",
                 n - 1, o_mv, o_mix, o_mix12, e_mv, e_mix, e_mix12);
      end
    end
    checks++;
    if (got != 30) begin failures++; $display("FAIL start_ch2 got=%0d need=30", got); end
    @(negedge clk);
    cen = 0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mix();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
